// File: rtl/ball_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ball_engine                                                 |
// | Purpose  : Pong game logic. Moves the ball once per motion tick,       |
// |            bounces it off the walls and paddles, detects misses, keeps |
// |            both scores and sequences serve / play / point / game over. |
// | Ports    : clk, rst      - clock, synchronous active-high reset        |
// |            en            - run enable, low freezes all state           |
// |            bat_size      - paddle height select (0 small, 1 large)     |
// |            p1_y, p2_y    - left / right paddle top y                   |
// |            bx, by        - ball top-left position                      |
// |            score1/2      - left / right player scores                  |
// |            hit, point    - one-clk event pulses                        |
// |            game_over     - high once a score reaches WIN_SCORE         |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module ball_engine #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BALL        = 8,
  parameter int P1_X        = 16,
  parameter int P2_X        = 616,
  parameter int PAD_W       = 8,
  parameter int PAD_H_S     = 48,
  parameter int PAD_H_L     = 96,
  parameter int SPEED       = 2,
  parameter int TICK_DIV    = 833333,
  parameter int SERVE_TICKS = 60,
  parameter int WIN_SCORE   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        bat_size,
  input  logic [10:0] p1_y,
  input  logic [10:0] p2_y,
  output logic [10:0] bx,
  output logic [10:0] by,
  output logic [5:0]  score1,
  output logic [5:0]  score2,
  output logic        hit,
  output logic        point,
  output logic        game_over
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  localparam logic [10:0] CX_V    = 11'((H_ACTIVE - BALL) / 2);
  localparam logic [10:0] CY_V    = 11'((V_ACTIVE - BALL) / 2);
  localparam logic [10:0] BOT_V   = 11'(V_ACTIVE - BALL);
  localparam logic [10:0] LFACE_V = 11'(P1_X + PAD_W);
  localparam logic [10:0] RFACE_V = 11'(P2_X - BALL);
  localparam logic [10:0] RMISS_V = 11'(H_ACTIVE - BALL);
  localparam logic [5:0]  WIN_V   = 6'(WIN_SCORE);

  localparam logic signed [11:0] SPD_S   = 12'(SPEED);
  localparam logic signed [11:0] ZERO_S  = 12'sd0;
  localparam logic signed [11:0] BOT_S   = $signed({1'b0, BOT_V});
  localparam logic signed [11:0] LFACE_S = $signed({1'b0, LFACE_V});
  localparam logic signed [11:0] RFACE_S = $signed({1'b0, RFACE_V});
  localparam logic signed [11:0] RMISS_S = $signed({1'b0, RMISS_V});
  localparam logic signed [12:0] BALL_S  = 13'(BALL);

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_PLAY  = 2'd1,
    S_POINT = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tcnt_q;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [10:0]     bx_q, bx_d, by_q, by_d;
  logic            dx_q, dx_d;   // 1 = moving right (+x)
  logic            dy_q, dy_d;   // 1 = moving down (+y)
  logic [5:0]      score1_q, score1_d, score2_q, score2_d;
  logic            hit_q, hit_d, point_q, point_d;

  logic               w_tick;
  logic signed [11:0] w_nx, w_ny;
  logic [10:0]        w_pad_h;
  logic               w_ov1, w_ov2;

  // Vertical overlap between the ball's next row span and a paddle. Done in
  // 13 bits so an unchecked paddle y near the top of the range cannot wrap.
  function automatic logic f_overlap(input logic signed [11:0] y,
                                     input logic [10:0]        py,
                                     input logic [10:0]        ph);
    logic signed [12:0] y_e, top_e, bot_e;
    y_e   = {y[11], y};
    top_e = $signed({2'b00, py});
    bot_e = $signed({2'b00, py}) + $signed({2'b00, ph});
    return ((y_e + BALL_S) > top_e) && (y_e < bot_e);
  endfunction

  assign w_tick  = en && (tcnt_q == TW'(TICK_DIV - 1));
  assign w_nx    = dx_q ? ($signed({1'b0, bx_q}) + SPD_S) : ($signed({1'b0, bx_q}) - SPD_S);
  assign w_ny    = dy_q ? ($signed({1'b0, by_q}) + SPD_S) : ($signed({1'b0, by_q}) - SPD_S);
  assign w_pad_h = bat_size ? 11'(PAD_H_L) : 11'(PAD_H_S);
  assign w_ov1   = f_overlap(w_ny, p1_y, w_pad_h);
  assign w_ov2   = f_overlap(w_ny, p2_y, w_pad_h);

  // Motion tick divider; holds its count while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
    end else if (en) begin
      tcnt_q <= w_tick ? '0 : tcnt_q + TW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bx_d     = bx_q;
    by_d     = by_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    score1_d = score1_q;
    score2_d = score2_q;
    hit_d    = 1'b0;
    point_d  = 1'b0;

    case (state_q)
      S_SERVE: begin
        bx_d = CX_V;
        by_d = CY_V;
        if (w_tick) begin
          if (scnt_q == SW'(SERVE_TICKS - 1)) begin
            state_d = S_PLAY;
            scnt_d  = '0;
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
      end

      S_PLAY: begin
        if (w_tick) begin
          // Vertical: walls
          if (w_ny <= ZERO_S) begin
            by_d = '0;
            dy_d = 1'b1;
          end else if (w_ny >= BOT_S) begin
            by_d = BOT_V;
            dy_d = 1'b0;
          end else begin
            by_d = w_ny[10:0];
          end

          // Horizontal: paddle face only counts when crossed this tick, so a
          // ball already behind the face carries on to the miss line.
          if (!dx_q) begin
            if ((w_nx <= LFACE_S) && (bx_q > LFACE_V) && w_ov1) begin
              bx_d  = LFACE_V;
              dx_d  = 1'b1;
              hit_d = 1'b1;
            end else if (w_nx <= ZERO_S) begin
              bx_d    = '0;
              point_d = 1'b1;
              state_d = S_POINT;
              if (score2_q < WIN_V) score2_d = score2_q + 6'd1;
            end else begin
              bx_d = w_nx[10:0];
            end
          end else begin
            if ((w_nx >= RFACE_S) && (bx_q < RFACE_V) && w_ov2) begin
              bx_d  = RFACE_V;
              dx_d  = 1'b0;
              hit_d = 1'b1;
            end else if (w_nx >= RMISS_S) begin
              bx_d    = RMISS_V;
              point_d = 1'b1;
              state_d = S_POINT;
              if (score1_q < WIN_V) score1_d = score1_q + 6'd1;
            end else begin
              bx_d = w_nx[10:0];
            end
          end
        end
      end

      S_POINT: begin
        // dx still points at the player who conceded, so the next serve
        // travels toward them; dy is deliberately left alone.
        bx_d   = CX_V;
        by_d   = CY_V;
        scnt_d = '0;
        if ((score1_q == WIN_V) || (score2_q == WIN_V)) begin
          state_d = S_OVER;
        end else begin
          state_d = S_SERVE;
        end
      end

      S_OVER: begin
        bx_d = CX_V;
        by_d = CY_V;
      end

      default: begin
        state_d = S_SERVE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_SERVE;
      scnt_q   <= '0;
      bx_q     <= CX_V;
      by_q     <= CY_V;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      score1_q <= '0;
      score2_q <= '0;
      hit_q    <= 1'b0;
      point_q  <= 1'b0;
    end else if (en) begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      hit_q    <= hit_d;
      point_q  <= point_d;
    end else begin
      hit_q   <= 1'b0;
      point_q <= 1'b0;
    end
  end

  assign bx        = bx_q;
  assign by        = by_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign hit       = hit_q;
  assign point     = point_q;
  assign game_over = (state_q == S_OVER);

endmodule
`default_nettype wire

// File: tb/tb_ball_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_ball_engine                                              |
// | Purpose  : Directed self-checking bench for ball_engine. Uses a fast   |
// |            tick (2 clks), 2 serve ticks and a winning score of 2 so    |
// |            whole rallies fit in a short run. Expected positions are    |
// |            hand-derived from the ball trajectory.                      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_ball_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        bat_size = 1'b0;
  logic [10:0] p1_y = 11'd164;
  logic [10:0] p2_y = 11'd412;
  logic [10:0] bx, by;
  logic [5:0]  score1, score2;
  logic        hit, point, game_over;

  int checks = 0;
  int errors = 0;

  ball_engine #(
    .TICK_DIV   (2),
    .SERVE_TICKS(2),
    .WIN_SCORE  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bat_size (bat_size),
    .p1_y     (p1_y),
    .p2_y     (p2_y),
    .bx       (bx),
    .by       (by),
    .score1   (score1),
    .score2   (score2),
    .hit      (hit),
    .point    (point),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Advance n clocks, landing 1 time unit after the last rising edge.
  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One motion tick is two clocks with TICK_DIV=2.
  task automatic ticks(input int n);
    clk_n(2 * n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_n(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bx !== 11'd316) begin errors++; $display("FAIL reset_bx: got %0d want 316", bx); end
    checks++; if (by !== 11'd236) begin errors++; $display("FAIL reset_by: got %0d want 236", by); end
    checks++; if (score1 !== 6'd0) begin errors++; $display("FAIL reset_score1: got %0d want 0", score1); end
    checks++; if (score2 !== 6'd0) begin errors++; $display("FAIL reset_score2: got %0d want 0", score2); end
    checks++; if ({hit, point, game_over} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {hit, point, game_over}); end
  endtask

  task automatic test_serve();
    ticks(2);
    checks++; if ({bx, by} !== {11'd316, 11'd236}) begin errors++; $display("FAIL serve_hold: got %0d,%0d want 316,236", bx, by); end
    ticks(1);
    checks++; if ({bx, by} !== {11'd318, 11'd238}) begin errors++; $display("FAIL first_move: got %0d,%0d want 318,238", bx, by); end
  endtask

  task automatic test_wall_bounce();
    ticks(116);
    checks++; if ({bx, by} !== {11'd550, 11'd470}) begin errors++; $display("FAIL pre_wall: got %0d,%0d want 550,470", bx, by); end
    ticks(1);
    checks++; if ({bx, by} !== {11'd552, 11'd472}) begin errors++; $display("FAIL wall_clamp: got %0d,%0d want 552,472", bx, by); end
    ticks(1);
    checks++; if ({bx, by} !== {11'd554, 11'd470}) begin errors++; $display("FAIL wall_reverse: got %0d,%0d want 554,470", bx, by); end
  endtask

  task automatic test_paddle_hits();
    ticks(26);
    checks++; if ({bx, by} !== {11'd606, 11'd418}) begin errors++; $display("FAIL pre_p2: got %0d,%0d want 606,418", bx, by); end
    ticks(1);
    checks++; if ({bx, by} !== {11'd608, 11'd416}) begin errors++; $display("FAIL p2_clamp: got %0d,%0d want 608,416", bx, by); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL p2_hit_pulse: got %b want 1", hit); end
    checks++; if ({score1, score2} !== 12'd0) begin errors++; $display("FAIL p2_scores: got %0d,%0d want 0,0", score1, score2); end
    p2_y = 11'd0;
    clk_n(1);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL p2_hit_width: got %b want 0", hit); end
    clk_n(1);
    checks++; if ({bx, by} !== {11'd606, 11'd414}) begin errors++; $display("FAIL p2_reverse: got %0d,%0d want 606,414", bx, by); end
    ticks(291);
    checks++; if ({bx, by, hit} !== {11'd24, 11'd168, 1'b1}) begin errors++; $display("FAIL p1_hit: got %0d,%0d hit=%b want 24,168 hit=1", bx, by, hit); end
    clk_n(1);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL p1_hit_width: got %b want 0", hit); end
    clk_n(1);
    checks++; if ({bx, by} !== {11'd26, 11'd170}) begin errors++; $display("FAIL p1_reverse: got %0d,%0d want 26,170", bx, by); end
  endtask

  task automatic test_right_miss();
    ticks(302);
    checks++; if ({bx, by, point} !== {11'd630, 11'd170, 1'b0}) begin errors++; $display("FAIL pre_miss: got %0d,%0d point=%b want 630,170 point=0", bx, by, point); end
    ticks(1);
    checks++; if ({point, score1, score2} !== {1'b1, 6'd1, 6'd0}) begin errors++; $display("FAIL right_miss: got point=%b s1=%0d s2=%0d want 1,1,0", point, score1, score2); end
    clk_n(1);
    checks++; if ({point, bx, by} !== {1'b0, 11'd316, 11'd236}) begin errors++; $display("FAIL miss_centre: got point=%b %0d,%0d want 0 316,236", point, bx, by); end
    clk_n(5);
    checks++; if ({bx, by} !== {11'd318, 11'd234}) begin errors++; $display("FAIL serve_to_p2: got %0d,%0d want 318,234", bx, by); end
  endtask

  task automatic test_freeze();
    clk_n(1);
    en = 1'b0;
    clk_n(50);
    checks++; if ({bx, by, score1, score2} !== {11'd318, 11'd234, 6'd1, 6'd0}) begin errors++; $display("FAIL freeze_hold: got %0d,%0d s=%0d,%0d want 318,234 s=1,0", bx, by, score1, score2); end
    en = 1'b1;
    clk_n(1);
    checks++; if ({bx, by} !== {11'd320, 11'd232}) begin errors++; $display("FAIL resume_tick: got %0d,%0d want 320,232", bx, by); end
    clk_n(2);
    checks++; if ({bx, by} !== {11'd322, 11'd230}) begin errors++; $display("FAIL resume_next: got %0d,%0d want 322,230", bx, by); end
  endtask

  task automatic test_game_over();
    p1_y = 11'd0;
    p2_y = 11'd412;
    do_reset();
    checks++; if ({score1, score2} !== 12'd0) begin errors++; $display("FAIL go_reset_scores: got %0d,%0d want 0,0", score1, score2); end
    ticks(148);
    checks++; if ({bx, by, hit} !== {11'd608, 11'd416, 1'b1}) begin errors++; $display("FAIL go_p2_hit: got %0d,%0d hit=%b want 608,416 hit=1", bx, by, hit); end
    clk_n(2);
    ticks(302);
    checks++; if ({bx, by} !== {11'd2, 11'd190}) begin errors++; $display("FAIL go_pre_miss1: got %0d,%0d want 2,190", bx, by); end
    ticks(1);
    checks++; if ({point, score2} !== {1'b1, 6'd1}) begin errors++; $display("FAIL go_miss1: got point=%b s2=%0d want 1,1", point, score2); end
    clk_n(1);
    checks++; if ({bx, by, game_over} !== {11'd316, 11'd236, 1'b0}) begin errors++; $display("FAIL go_centre1: got %0d,%0d go=%b want 316,236 go=0", bx, by, game_over); end
    clk_n(5);
    checks++; if ({bx, by} !== {11'd314, 11'd238}) begin errors++; $display("FAIL serve_to_p1: got %0d,%0d want 314,238", bx, by); end
    ticks(156);
    checks++; if ({bx, by} !== {11'd2, 11'd394}) begin errors++; $display("FAIL go_pre_miss2: got %0d,%0d want 2,394", bx, by); end
    ticks(1);
    checks++; if ({point, score2, game_over} !== {1'b1, 6'd2, 1'b0}) begin errors++; $display("FAIL go_miss2: got point=%b s2=%0d go=%b want 1,2,0", point, score2, game_over); end
    clk_n(1);
    checks++; if ({game_over, bx, by} !== {1'b1, 11'd316, 11'd236}) begin errors++; $display("FAIL go_enter: got go=%b %0d,%0d want 1 316,236", game_over, bx, by); end
    ticks(100);
    checks++; if ({game_over, bx, by, score1, score2, point} !== {1'b1, 11'd316, 11'd236, 6'd0, 6'd2, 1'b0}) begin errors++; $display("FAIL go_hold: got go=%b %0d,%0d s=%0d,%0d p=%b want 1 316,236 s=0,2 p=0", game_over, bx, by, score1, score2, point); end
    en  = 1'b0;
    rst = 1'b1;
    clk_n(1);
    checks++; if ({game_over, score1, score2, bx, by} !== {1'b0, 6'd0, 6'd0, 11'd316, 11'd236}) begin errors++; $display("FAIL go_rst: got go=%b s=%0d,%0d %0d,%0d want 0 s=0,0 316,236", game_over, score1, score2, bx, by); end
    rst = 1'b0;
    en  = 1'b1;
    clk_n(2);
    checks++; if ({game_over, bx, by} !== {1'b0, 11'd316, 11'd236}) begin errors++; $display("FAIL post_rst_serve: got go=%b %0d,%0d want 0 316,236", game_over, bx, by); end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_wall_bounce();
    test_paddle_hits();
    test_right_miss();
    test_freeze();
    test_game_over();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
